// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state encoding, frame geometry, default bit time.
// No logic; both the transmitter and the receiver import these constants.
// Frame layout helper builds the 10-bit {stop, data, start} word shifted out LSB first.
package uart_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        TRANSMIT = 1'b1
    } tx_state_t;

    localparam int FRAME_BITS          = 10;
    localparam int BAUD_CYCLES_DEFAULT = 2604;   // 50 MHz / 19200 baud
    localparam int BAUD_W              = 12;
    localparam int BIT_W               = 4;

    function automatic logic [FRAME_BITS-1:0] frame_of(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with occupancy count and full/empty flags.
// Latency: a pushed word is visible on rdata the cycle after the push edge.
// Backpressure: push while full is ignored; pop while empty is ignored.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Flags come from the pre-edge count, so a push at full is dropped even with a same-cycle pop.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_queued.sv
// Queued 8N1 UART transmitter: host bytes buffered in a small FIFO, sent LSB first on TX.
// Latency: strobe at edge k -> load at k+1 -> start bit on TX from k+2; bit = BAUD_CYCLES clks.
// Backpressure: tx_full flags a full queue; trmt while full drops the byte silently.
module uart_tx_queued
    import uart_pkg::*;
#(
    parameter int BAUD_CYCLES = BAUD_CYCLES_DEFAULT,
    parameter int DEPTH       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_full,
    output logic       tx_empty
);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CYCLES - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);

    tx_state_t             state;
    tx_state_t             state_nxt;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] shift_nxt;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [BAUD_W-1:0]     baud_nxt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [BIT_W-1:0]      bit_nxt;
    logic                  busy_nxt;
    logic                  done_nxt;
    logic                  fifo_pop;
    logic [7:0]            fifo_rdata;
    logic                  baud_tick;

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (trmt),
        .pop   (fifo_pop),
        .wdata (tx_data),
        .rdata (fifo_rdata),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign baud_tick = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        busy_nxt  = tx_busy;
        done_nxt  = 1'b0;
        fifo_pop  = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_empty) begin
                    fifo_pop  = 1'b1;
                    shift_nxt = frame_of(fifo_rdata);
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = TRANSMIT;
                end
            end
            TRANSMIT: begin
                if (baud_tick) begin
                    baud_nxt  = '0;
                    shift_nxt = {1'b1, shift_reg[FRAME_BITS-1:1]};
                    bit_nxt   = bit_cnt + 1'b1;
                    // Stop bit ends on this tick; returning to IDLE now lets the next
                    // frame load in the tx_done cycle, leaving a single idle clock.
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Shift register idles at all ones (stop bits shifted in), so TX stays high between frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '1;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            TX        <= 1'b1;
        end else begin
            shift_reg <= shift_nxt;
            baud_cnt  <= baud_nxt;
            bit_cnt   <= bit_nxt;
            tx_busy   <= busy_nxt;
            tx_done   <= done_nxt;
            TX        <= shift_reg[0];
        end
    end

endmodule

// File: tb/tb_uart_tx_queued.sv
// Bench for uart_tx_queued: directed frames, queueing, overflow, async reset, random loopback.
// Expected bytes are queued at stimulus time; a serial monitor decodes TX and compares.
module tb_uart_tx_queued;

    localparam int B     = 8;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * B;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       trmt    = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       TX;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_full;
    logic       tx_empty;

    int         checks     = 0;
    int         failures   = 0;
    int         accepted   = 0;
    int         mon_frames = 0;
    logic [7:0] exp_q[$];

    uart_tx_queued #(
        .BAUD_CYCLES (B),
        .DEPTH       (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .TX       (TX),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_full  (tx_full),
        .tx_empty (tx_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Serial monitor: start detected on first low sample, then mid-bit sampling.
    initial begin : monitor
        int         cnt;
        int         j;
        logic       active;
        logic [7:0] b;
        active = 1'b0;
        cnt    = 0;
        b      = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                active = 1'b0;
            end else if (!active) begin
                if (TX === 1'b0) begin
                    active = 1'b1;
                    cnt    = 0;
                end
            end else begin
                cnt++;
                if (cnt >= B/2 && ((cnt - B/2) % B) == 0) begin
                    j = (cnt - B/2) / B;
                    if (j == 0) begin
                        check("mon_start_bit", TX, 1'b0);
                    end else if (j <= 8) begin
                        b[j-1] = TX;
                    end else begin
                        check("mon_stop_bit", TX, 1'b1);
                        active = 1'b0;
                        mon_frames++;
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL mon_unexpected_frame: got %0h, want none", b);
                        end else begin
                            check("mon_byte", b, exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin : idle_watch
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && TX !== 1'b1)
                check("tx_low_only_when_busy", tx_busy, 1'b1);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic [7:0] b, input bit acc);
        trmt    = 1'b1;
        tx_data = b;
        if (acc) begin
            exp_q.push_back(b);
            accepted++;
        end
        @(negedge clk);
        trmt = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_done !== 1'b1 && n < FRAME + 20);
        check(name, tx_done, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(tx_empty === 1'b1 && tx_busy === 1'b0) && n < 6*(FRAME+1) + 20) begin
            @(negedge clk);
            n++;
        end
        check(name, {30'd0, tx_empty, tx_busy}, 32'd2);
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        int first_low, low_end, busy_first, busy_cnt, done_cnt, done_n, tx_low_cnt;
        int d[3];
        int sent;

        // Reset state (held low from time 0)
        repeat (2) @(negedge clk);
        check("rst_TX", TX, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        check("rst_full", tx_full, 1'b0);
        check("rst_empty", tx_empty, 1'b1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Test 1: single 0xA5 frame timing
        drive(8'hA5, 1'b1);
        check("t1_empty_after_push", tx_empty, 1'b0);
        check("t1_busy_n1", tx_busy, 1'b0);
        first_low = 0; low_end = 0; busy_first = 0; busy_cnt = 0; done_cnt = 0; done_n = 0;
        for (int n = 2; n <= FRAME + 6; n++) begin
            @(negedge clk);
            if (TX === 1'b0 && first_low == 0) first_low = n;
            if (TX === 1'b1 && first_low != 0 && low_end == 0) low_end = n;
            if (tx_busy === 1'b1) begin
                busy_cnt++;
                if (busy_first == 0) busy_first = n;
            end
            if (tx_done === 1'b1) begin
                done_cnt++;
                done_n = n;
            end
        end
        check("t1_tx_low_at_k2", first_low, 3);
        check("t1_start_bit_len", low_end - first_low, B);
        check("t1_busy_start", busy_first, 2);
        check("t1_busy_len", busy_cnt, FRAME);
        check("t1_done_count", done_cnt, 1);
        check("t1_done_time", done_n, FRAME + 2);
        wait_idle("t1_idle");

        // Test 2: three back-to-back strobes
        drive(8'h00, 1'b1);
        drive(8'hFF, 1'b1);
        drive(8'h55, 1'b1);
        done_cnt = 0;
        for (int n = 1; n <= 3*(FRAME+1) + 20; n++) begin
            @(negedge clk);
            if (tx_done === 1'b1) begin
                if (done_cnt < 3) d[done_cnt] = n;
                done_cnt++;
            end
        end
        check("t2_done_count", done_cnt, 3);
        check("t2_gap_1", d[1] - d[0], FRAME + 1);
        check("t2_gap_2", d[2] - d[1], FRAME + 1);
        wait_idle("t2_idle");

        // Test 3: overflow while a frame is in flight
        drive(8'h11, 1'b1);
        repeat (5) @(negedge clk);
        drive(8'h21, 1'b1);
        drive(8'h22, 1'b1);
        drive(8'h23, 1'b1);
        check("t3_not_full_at_3", tx_full, 1'b0);
        drive(8'h24, 1'b1);
        check("t3_full_at_4", tx_full, 1'b1);
        drive(8'h25, 1'b0);
        check("t3_full_after_drop", tx_full, 1'b1);
        done_cnt = 0;
        for (int n = 1; n <= 5*(FRAME+1) + 30; n++) begin
            @(negedge clk);
            if (tx_done === 1'b1) done_cnt++;
        end
        check("t3_done_count", done_cnt, 5);
        check("t3_empty_end", tx_empty, 1'b1);
        wait_idle("t3_idle");

        // Test 4: async reset during data bit 3
        drive(8'h5A, 1'b0);
        drive(8'h6B, 1'b0);
        repeat (3 + 4*B + B/2 - 2) @(negedge clk);
        check("t4_busy_before_rst", tx_busy, 1'b1);
        check("t4_bit3_on_line", TX, 1'b1);
        check("t4_queued_before_rst", tx_empty, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_TX", TX, 1'b1);
        check("t4_rst_busy", tx_busy, 1'b0);
        check("t4_rst_empty", tx_empty, 1'b1);
        check("t4_rst_done", tx_done, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0; tx_low_cnt = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (tx_done === 1'b1) done_cnt++;
            if (TX !== 1'b1) tx_low_cnt++;
        end
        check("t4_no_done_after_rst", done_cnt, 0);
        check("t4_line_idle_after_rst", tx_low_cnt, 0);
        drive(8'h3C, 1'b1);
        wait_done("t4_done_3c");
        wait_idle("t4_idle");

        // Test 5: push at full with same-cycle pop, and push with same-cycle last pop
        drive(8'h81, 1'b1);
        repeat (3) @(negedge clk);
        drive(8'h82, 1'b1);
        drive(8'h83, 1'b1);
        drive(8'h84, 1'b1);
        drive(8'h85, 1'b1);
        wait_done("t5_done1");
        check("t5_full_before_pop", tx_full, 1'b1);
        drive(8'h99, 1'b0);
        check("t5_count_dm1", tx_full, 1'b0);
        check("t5_not_empty_dm1", tx_empty, 1'b0);
        wait_done("t5_done2");
        wait_done("t5_done3");
        wait_done("t5_done4");
        check("t5_one_left", tx_empty, 1'b0);
        drive(8'h9A, 1'b1);
        check("t5_push_pop_kept", tx_empty, 1'b0);
        wait_idle("t5_idle");

        // Test 6: random bytes in small bursts with random spacing
        sent = 0;
        while (sent < 256) begin
            int grp;
            grp = $urandom_range(1, 4);
            for (int g = 0; g < grp; g++) begin
                if (sent < 256) begin
                    drive(8'($urandom_range(0, 255)), 1'b1);
                    sent++;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            wait_idle("t6_idle");
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        repeat (B) @(negedge clk);
        check("end_queue_drained", exp_q.size(), 0);
        check("end_frame_count", mon_frames, accepted);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
